// File: rtl/pcs_pkg.sv
// ============================================================================
// Package : pcs_pkg
// Brief   : Shared 100BASE-X PCS cipher taps, lock states and timeout defaults.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pcs_pkg;

   // x^11 + x^9 + 1 cipher
   localparam int c_lfsr_w = 11;
   localparam int c_tap_hi = 10;
   localparam int c_tap_lo = 8;

   localparam int c_unlock_cycles       = 45125;
   localparam int c_jumbo_unlock_cycles = 76000;
   localparam int c_test_unlock_cycles  = 625;

   typedef enum logic [0:0] {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/descramble_step.sv
// ============================================================================
// Module : descramble_step
// Brief  : One serial descrambler step: key, output bit and next cipher state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module descramble_step
   import pcs_pkg::*;
(
   input  logic [c_lfsr_w-1:0] lfsr,
   input  logic                b,
   input  logic                locked,
   output logic [c_lfsr_w-1:0] lfsr_next,
   output logic                out,
   output logic                k
);

   assign k         = lfsr[c_tap_hi] ^ lfsr[c_tap_lo];
   assign out       = b ^ k;
   // While training, ~b recovers the cipher bit from an idle (all-ones) stream
   assign lfsr_next = {lfsr[c_lfsr_w-2:0], (locked ? k : ~b)};

endmodule

`default_nettype wire

// File: rtl/descramble_n.sv
// ============================================================================
// Module : descramble_n
// Brief  : WIDTH-bit-per-beat 100BASE-X receive descrambler with idle lock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module descramble_n
   import pcs_pkg::*;
#(
   parameter int WIDTH               = 2,
   parameter int IDLE_LOCK           = 29,
   parameter int UNLOCK_CYCLES       = c_unlock_cycles,
   parameter int JUMBO_UNLOCK_CYCLES = c_jumbo_unlock_cycles,
   parameter int TEST_UNLOCK_CYCLES  = c_test_unlock_cycles
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             scrambled,
   input  logic [$clog2(WIDTH+1)-1:0]   scrambled_valid,
   input  logic                         signal_status,
   input  logic                         test_mode,
   input  logic                         jumbo_mode,
   input  logic                         force_relock,
   output logic                         locked,
   output logic [WIDTH-1:0]             descrambled,
   output logic [$clog2(WIDTH+1)-1:0]   descrambled_valid,
   output logic [7:0]                   lock_lost_count
);

   localparam int c_valid_w = $clog2(WIDTH+1);
   localparam int c_max_a   = (UNLOCK_CYCLES > JUMBO_UNLOCK_CYCLES) ? UNLOCK_CYCLES
                                                                    : JUMBO_UNLOCK_CYCLES;
   localparam int c_max_to  = (c_max_a > TEST_UNLOCK_CYCLES) ? c_max_a : TEST_UNLOCK_CYCLES;
   localparam int c_timer_w = $clog2(c_max_to + 1);

   logic [c_lfsr_w-1:0]  r_lfsr;
   logic [5:0]           r_run;
   logic                 r_relock;
   lock_state_t          r_state, w_state_nx;
   logic [c_timer_w-1:0] r_timer, w_timer_nx, w_timeout;
   logic [7:0]           r_lost;
   logic                 w_lost_inc;
   logic [WIDTH-1:0]     r_desc, w_desc;
   logic [c_valid_w-1:0] r_dvalid, w_nvalid;
   logic                 w_locked;

   logic [c_lfsr_w-1:0]  w_lfsr_chain [0:WIDTH];
   logic [5:0]           w_run_chain  [0:WIDTH];
   logic [WIDTH:0]       w_evt_chain;

   assign w_locked = (r_state == LOCKED);
   assign w_nvalid = (scrambled_valid > c_valid_w'(WIDTH)) ? c_valid_w'(WIDTH) : scrambled_valid;

   assign w_lfsr_chain[0] = r_lfsr;
   assign w_run_chain[0]  = r_run;
   assign w_evt_chain[0]  = 1'b0;

   // Oldest bit (MSB) is processed first; invalid positions pass state through
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_step
         logic                w_b, w_vld, w_out, w_k;
         logic [c_lfsr_w-1:0] w_lfsr_nx;

         assign w_b   = scrambled[WIDTH-1-i];
         assign w_vld = (c_valid_w'(i) < w_nvalid);

         descramble_step u_step (
            .lfsr      (w_lfsr_chain[i]),
            .b         (w_b),
            .locked    (w_locked),
            .lfsr_next (w_lfsr_nx),
            .out       (w_out),
            .k         (w_k)
         );

         assign w_desc[WIDTH-1-i] = w_b ^ w_k;
         assign w_lfsr_chain[i+1] = w_vld ? w_lfsr_nx : w_lfsr_chain[i];
         assign w_run_chain[i+1]  = !w_vld ? w_run_chain[i] :
                                    !w_out ? 6'd0 :
                                    (w_run_chain[i] == 6'(IDLE_LOCK)) ? w_run_chain[i]
                                                                     : w_run_chain[i] + 6'd1;
         assign w_evt_chain[i+1]  = w_evt_chain[i] |
                                    (w_vld & w_out & (w_run_chain[i+1] == 6'(IDLE_LOCK)));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr   <= '0;
         r_run    <= '0;
         r_relock <= 1'b0;
         r_desc   <= '0;
         r_dvalid <= '0;
      end else begin
         r_desc <= w_desc;
         if (!signal_status) begin
            r_lfsr   <= '0;
            r_run    <= '0;
            r_relock <= 1'b0;
            r_dvalid <= '0;
         end else begin
            r_lfsr   <= w_lfsr_chain[WIDTH];
            r_dvalid <= scrambled_valid;
            if (force_relock) begin
               r_run    <= '0;
               r_relock <= 1'b0;
            end else begin
               r_run    <= w_run_chain[WIDTH];
               r_relock <= w_evt_chain[WIDTH];
            end
         end
      end
   end

   assign w_timeout = test_mode  ? c_timer_w'(TEST_UNLOCK_CYCLES)  :
                      jumbo_mode ? c_timer_w'(JUMBO_UNLOCK_CYCLES) :
                                   c_timer_w'(UNLOCK_CYCLES);

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer;
      w_lost_inc = 1'b0;
      if (!signal_status) begin
         w_state_nx = UNLOCKED;
         w_timer_nx = '0;
      end else if (force_relock) begin
         w_state_nx = UNLOCKED;
         w_lost_inc = w_locked;
      end else begin
         case (r_state)
            UNLOCKED: begin
               if (r_relock) begin
                  w_state_nx = LOCKED;
                  w_timer_nx = w_timeout;
               end
            end
            LOCKED: begin
               if (r_relock) begin
                  w_timer_nx = w_timeout;
               end else if (r_timer == '0) begin
                  w_state_nx = UNLOCKED;
                  w_lost_inc = 1'b1;
               end else begin
                  w_timer_nx = r_timer - c_timer_w'(1);
               end
            end
            default: w_state_nx = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= UNLOCKED;
         r_timer <= '0;
         r_lost  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_timer <= w_timer_nx;
         if (w_lost_inc && (r_lost != 8'hFF)) begin
            r_lost <= r_lost + 8'd1;
         end
      end
   end

   assign locked            = w_locked;
   assign descrambled       = r_desc;
   assign descrambled_valid = r_dvalid;
   assign lock_lost_count   = r_lost;

endmodule

`default_nettype wire

// File: doc/descramble_n.md
# descramble_n

Parametrised 100BASE-X PCS receive descrambler. It accepts WIDTH scrambled code bits per clock with a per-beat valid count, and recovers the 11-bit cipher stream from idle runs. It holds lock under a mode-selected unlock timeout and emits descrambled bits one cycle later. It sits between the PMA/NRZI decoder and the 4B/5B aligner and generalises the fixed 2-bit descrambler to 1–8 bits per beat, adding jumbo mode, forced relock and lock-loss statistics.

## Interface
- WIDTH, 2: code bits per beat, 1..8.
- IDLE_LOCK, 29: consecutive descrambled ones required to lock or refresh lock, 12..59.
- UNLOCK_CYCLES, 45125: timeout in normal mode; must exceed 361 µs at 125 MHz.
- JUMBO_UNLOCK_CYCLES, 76000: timeout when jumbo_mode.
- TEST_UNLOCK_CYCLES, 625: timeout when test_mode; test_mode has priority over jumbo_mode.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scrambled  in  WIDTH  code bits; the valid bits are the top `scrambled_valid` bits, and scrambled[WIDTH-1] is the oldest.
- scrambled_valid  in  $clog2(WIDTH+1)  number of valid bits, 0..WIDTH. Values above WIDTH are treated as WIDTH.
- signal_status  in  1  PMD signal detect; when low, synchronous clear.
- test_mode, jumbo_mode  in  1  timeout select.
- force_relock  in  1  single-cycle pulse that drops lock immediately.
- locked  out  1  descrambler synchronised.
- descrambled  out  WIDTH  descrambled bits, same alignment as the input.
- descrambled_valid  out  $clog2(WIDTH+1)  registered copy of scrambled_valid.
- lock_lost_count  out  8  saturating count of timeout/forced unlocks.

## Operation
- Cipher: 11-bit LFSR, x^11+x^9+1. The key bit is k = lfsr[8]^lfsr[10].
- Each beat is an unrolled chain of up to WIDTH serial steps, oldest bit first. For each valid bit b:
  - out = b^k.
  - lfsr shifts left, inserting k if locked, else ~b.
  - Inverting b cancels the idle ones, so training converges after 11 idle bits.
- Invalid bit positions leave lfsr unchanged. The corresponding descrambled bits are don't-care.
- Idle run counter (6 bits):
  - +1 per valid descrambled 1; cleared to 0 on a valid descrambled 0.
  - Saturates at IDLE_LOCK.
  - Evaluated in bit order within a beat.
- relock_evt: the run count reaches IDLE_LOCK at any point in the beat (including while already saturated). It is registered into relock.
- FSM states:
  - UNLOCKED: lfsr trains from input; locked=0. Goes to LOCKED when relock is set; the timer loads the selected timeout.
  - LOCKED: lfsr free-runs; locked=1.
    - relock set: timer reloads.
    - Otherwise, if timer==0: go to UNLOCKED and increment lock_lost_count.
    - Otherwise: timer decrements.
- force_relock takes priority over relock:
  - LOCKED goes to UNLOCKED and increments lock_lost_count.
  - Run counter clears and relock clears.
- The timer is a binary down-counter, width $clog2(max timeout+1). The timeout is sampled at load time.
- signal_status=0 (synchronous, above all else):
  - lfsr=0, run counter=0, relock=0, timer=0, state UNLOCKED, descrambled_valid=0.
  - lock_lost_count holds.
- rst_n=0 (asynchronous):
  - All of the above cleared.
  - descrambled=0, lock_lost_count=0.

## Timing
- descrambled and descrambled_valid follow the input beat by exactly 1 cycle. descrambled updates every cycle regardless of signal_status.
- Lock latency:
  - relock_evt in the beat sampled at edge N sets relock at edge N.
  - locked rises at edge N+1.
- locked stays high for exactly T+1 cycles after the load edge with no further relock, where T is the selected timeout. It falls at the edge where timer==0 is observed.
- force_relock sampled at edge N: locked=0 after edge N.
- Simultaneous relock and timer==0: relock wins, no unlock, no count.
- Simultaneous force_relock and timeout: a single increment.
- lock_lost_count at 255 stays at 255.
- Critical path is the WIDTH-step serial chain. No multi-cycle paths.

## Structure
- Shared package pcs_pkg:
  - LFSR tap positions.
  - Lock state enum {UNLOCKED, LOCKED}.
  - Default timeout constants: 45125 / 76000 / 625.
- Sub-module descramble_step: combinational single-bit step with inputs lfsr, b, locked and outputs lfsr', out, k. It is instantiated WIDTH times in a generate chain.

## Test plan
- Reset, WIDTH=2: rst_n low mid-stream → locked=0, descrambled=0, descrambled_valid=0, lock_lost_count=0 immediately, without waiting for a clock edge.
- Idle lock, WIDTH=2, count=2 each cycle, idles scrambled with seed 0x7FF → locked rises within 22 cycles of the first beat; descrambled=2'b11 thereafter.
- Timeout, test_mode=1: after lock, inject all-zero data → locked falls exactly 626 cycles after the last load edge; lock_lost_count=1.
- Partial beats, WIDTH=4: counts cycle 0,1,3,4,2 on a random scrambled stream → output bit-exact with a serial golden model; lfsr frozen on count=0.
- signal_status drop while locked with lock_lost_count=3 → next edge locked=0, descrambled_valid=0, lock_lost_count stays 3; relock after ≥40 idle bits.
- force_relock pulse while locked, jumbo_mode=1 → locked=0 next edge, count +1; relock on idles; timer loads 76000.
